// File: rtl/dcache_2way.sv
// dcache_2way: 2-way set-associative write-back, write-allocate data cache.
// Ports: clock/reset, byte-wide CPU port, block-wide memory port, hit/miss counters.
module dcache_2way #(
  parameter int ADDR_W      = 8,
  parameter int SETS        = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int CNT_W       = 16
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    cpu_read,
  input  logic                                    cpu_write,
  input  logic [ADDR_W-1:0]                       cpu_address,
  input  logic [7:0]                              cpu_writedata,
  output logic [7:0]                              cpu_readdata,
  output logic                                    busywait,
  output logic                                    mem_read,
  output logic                                    mem_write,
  output logic [ADDR_W-$clog2(BLOCK_WORDS)-1:0]   mem_address,
  output logic [8*BLOCK_WORDS-1:0]                mem_writedata,
  input  logic [8*BLOCK_WORDS-1:0]                mem_readdata,
  input  logic                                    mem_busywait,
  output logic [CNT_W-1:0]                        hit_count,
  output logic [CNT_W-1:0]                        miss_count
);

  localparam int OFF_W   = $clog2(BLOCK_WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_W   = ADDR_W - IDX_W - OFF_W;
  localparam int BLOCK_W = 8 * BLOCK_WORDS;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH,
    FILL
  } state_t;

  state_t state;

  logic [TAG_W-1:0]   tag_q  [2][SETS];
  logic [BLOCK_W-1:0] data_q [2][SETS];
  logic [SETS-1:0]    valid_q [2];
  logic [SETS-1:0]    dirty_q [2];
  // lru_q[set] names the way to evict next
  logic [SETS-1:0]    lru_q;

  logic               miss_pending;
  logic               victim;
  logic [BLOCK_W-1:0] fill_buf;

  logic [OFF_W-1:0]   off;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [OFF_W+2:0]   bsel;
  logic               access;
  logic               match0;
  logic               match1;
  logic               hit;
  logic               miss;
  logic               hit_way;
  logic               victim_next;
  logic               victim_dirty;

  assign off    = cpu_address[OFF_W-1:0];
  assign idx    = cpu_address[OFF_W +: IDX_W];
  assign tag    = cpu_address[ADDR_W-1 -: TAG_W];
  assign bsel   = {off, 3'b000};
  assign access = cpu_read ^ cpu_write;

  assign match0 = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign match1 = valid_q[1][idx] && (tag_q[1][idx] == tag);

  assign hit     = (state == IDLE) && access && (match0 || match1);
  assign miss    = (state == IDLE) && access && !(match0 || match1);
  assign hit_way = match1;

  assign busywait = (state != IDLE) || miss;

  assign cpu_readdata = (hit && cpu_read) ?
    data_q[hit_way][idx][bsel +: 8] : 8'h00;

  // Fill empty ways first, then evict the least recently used one
  assign victim_next = !valid_q[0][idx] ? 1'b0 :
                       !valid_q[1][idx] ? 1'b1 : lru_q[idx];
  assign victim_dirty = valid_q[victim_next][idx] &&
                        dirty_q[victim_next][idx];

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      valid_q[0]    <= '0;
      valid_q[1]    <= '0;
      dirty_q[0]    <= '0;
      dirty_q[1]    <= '0;
      lru_q         <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      miss_pending  <= 1'b0;
      victim        <= 1'b0;
      fill_buf      <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            if (cpu_write) begin
              data_q[hit_way][idx][bsel +: 8] <= cpu_writedata;
              dirty_q[hit_way][idx]           <= 1'b1;
            end
            lru_q[idx] <= ~hit_way;
            // The retried access of a refilled miss is not a hit
            if (miss_pending)
              miss_pending <= 1'b0;
            else if (hit_count != '1)
              hit_count <= hit_count + CNT_W'(1);
          end else if (miss) begin
            miss_pending <= 1'b1;
            victim       <= victim_next;
            if (miss_count != '1)
              miss_count <= miss_count + CNT_W'(1);
            if (victim_dirty) begin
              state         <= WRITEBACK;
              mem_write     <= 1'b1;
              mem_address   <= {tag_q[victim_next][idx], idx};
              mem_writedata <= data_q[victim_next][idx];
            end else begin
              state       <= FETCH;
              mem_read    <= 1'b1;
              mem_address <= cpu_address[ADDR_W-1:OFF_W];
            end
          end
        end
        WRITEBACK: begin
          if (!mem_busywait) begin
            state         <= FETCH;
            mem_write     <= 1'b0;
            mem_writedata <= '0;
            mem_read      <= 1'b1;
            mem_address   <= cpu_address[ADDR_W-1:OFF_W];
          end
        end
        FETCH: begin
          if (!mem_busywait) begin
            state       <= FILL;
            mem_read    <= 1'b0;
            mem_address <= '0;
            fill_buf    <= mem_readdata;
          end
        end
        FILL: begin
          data_q[victim][idx]  <= fill_buf;
          tag_q[victim][idx]   <= tag;
          valid_q[victim][idx] <= 1'b1;
          dirty_q[victim][idx] <= 1'b0;
          state                <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_2way.sv
// tb_dcache_2way: directed bench with a cycle-level reference model of the cache.
// A second small-counter instance exercises counter saturation.
module tb_dcache_2way;

  logic        clock;
  logic        reset;
  logic        cpu_read;
  logic        cpu_write;
  logic [7:0]  cpu_address;
  logic [7:0]  cpu_writedata;
  logic [7:0]  cpu_readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  logic        s_read;
  logic [7:0]  s_addr;
  logic [7:0]  s_readdata;
  logic        s_busywait;
  logic        s_mem_read;
  logic        s_mem_write;
  logic [5:0]  s_mem_address;
  logic [31:0] s_mem_writedata;
  logic [3:0]  s_hit_count;
  logic [3:0]  s_miss_count;

  int n_cmp = 0;
  int n_bad = 0;

  dcache_2way dut (
    .clock(clock), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_writedata(cpu_writedata),
    .cpu_readdata(cpu_readdata), .busywait(busywait),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  dcache_2way #(.CNT_W(4)) dut_s (
    .clock(clock), .reset(reset),
    .cpu_read(s_read), .cpu_write(1'b0),
    .cpu_address(s_addr), .cpu_writedata(8'h00),
    .cpu_readdata(s_readdata), .busywait(s_busywait),
    .mem_read(s_mem_read), .mem_write(s_mem_write),
    .mem_address(s_mem_address), .mem_writedata(s_mem_writedata),
    .mem_readdata(32'h0), .mem_busywait(1'b0),
    .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  always #5 clock = ~clock;

  // Block memory: busy for lat cycles per request
  logic [31:0] mem [64];
  int lat = 0;
  int mcnt = 0;

  assign mem_busywait = (mem_read || mem_write) && (mcnt < lat);
  assign mem_readdata = mem_read ? mem[mem_address] : 32'h0;

  always @(posedge clock) begin
    if (reset || !(mem_read || mem_write) || !mem_busywait)
      mcnt <= 0;
    else
      mcnt <= mcnt + 1;
    if (mem_write && !mem_busywait)
      mem[mem_address] <= mem_writedata;
  end

  // Memory traffic monitor
  bit          saw_rd, saw_wr;
  logic [5:0]  rd_addr, wr_addr;
  logic [31:0] wr_data;
  longint      rd_t, wr_t;

  always @(negedge clock) begin
    if (mem_write && !saw_wr) begin
      saw_wr = 1; wr_addr = mem_address;
      wr_data = mem_writedata; wr_t = $time;
    end
    if (mem_read && !saw_rd) begin
      saw_rd = 1; rd_addr = mem_address; rd_t = $time;
    end
  end

  task automatic clr_flags();
    saw_rd = 0; saw_wr = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    rd_t = 0; wr_t = 0;
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: sets of two lines, LRU by last-use timestamp
  bit          m_valid [4][2];
  bit          m_dirty [4][2];
  logic [3:0]  m_tag   [4][2];
  logic [31:0] m_data  [4][2];
  longint      m_use   [4][2];
  int          m_phase;   // 0 idle, 1 write-back, 2 fetch, 3 fill
  bit          m_pend;
  int          m_vic;
  logic [31:0] m_buf;
  longint      m_hits, m_misses, tnow;
  int          ms, mw, mo;

  function automatic int lookup(input logic [7:0] a);
    int s = int'(a[3:2]);
    for (int w = 0; w < 2; w++)
      if (m_valid[s][w] && m_tag[s][w] == a[7:4]) return w;
    return -1;
  endfunction

  always @(posedge clock) begin
    tnow++;
    if (reset) begin
      for (int s = 0; s < 4; s++)
        for (int w = 0; w < 2; w++) begin
          m_valid[s][w] = 0; m_dirty[s][w] = 0; m_use[s][w] = 0;
        end
      m_phase = 0; m_pend = 0; m_hits = 0; m_misses = 0;
    end else begin
      ms = int'(cpu_address[3:2]);
      mo = int'(cpu_address[1:0]);
      case (m_phase)
        0: if (cpu_read ^ cpu_write) begin
          mw = lookup(cpu_address);
          if (mw >= 0) begin
            if (cpu_write) begin
              m_data[ms][mw][mo*8 +: 8] = cpu_writedata;
              m_dirty[ms][mw] = 1;
            end
            m_use[ms][mw] = tnow;
            if (m_pend) m_pend = 0;
            else m_hits++;
          end else begin
            m_misses++;
            m_pend = 1;
            if (!m_valid[ms][0]) m_vic = 0;
            else if (!m_valid[ms][1]) m_vic = 1;
            else m_vic = (m_use[ms][0] <= m_use[ms][1]) ? 0 : 1;
            m_phase = m_dirty[ms][m_vic] ? 1 : 2;
          end
        end
        1: if (!mem_busywait) m_phase = 2;
        2: if (!mem_busywait) begin
          m_buf = mem_readdata; m_phase = 3;
        end
        default: begin
          m_valid[ms][m_vic] = 1;
          m_dirty[ms][m_vic] = 0;
          m_tag[ms][m_vic]   = cpu_address[7:4];
          m_data[ms][m_vic]  = m_buf;
          m_phase = 0;
        end
      endcase
    end
  end

  // Per-cycle comparison of every DUT output against the model
  bit chk_en = 0;
  int cs, cw;
  bit cacc, chit;
  logic [7:0]  e_rd;
  logic [5:0]  e_ma;
  logic [31:0] e_md;

  always @(negedge clock) begin
    if (chk_en) begin
      cs   = int'(cpu_address[3:2]);
      cw   = lookup(cpu_address);
      cacc = cpu_read ^ cpu_write;
      chit = (m_phase == 0) && cacc && (cw >= 0);
      e_rd = (chit && cpu_read) ?
        m_data[cs][cw][int'(cpu_address[1:0])*8 +: 8] : 8'h00;
      e_ma = 6'h00;
      e_md = 32'h0;
      if (m_phase == 1) begin
        e_ma = {m_tag[cs][m_vic], cpu_address[3:2]};
        e_md = m_data[cs][m_vic];
      end else if (m_phase == 2) begin
        e_ma = cpu_address[7:2];
      end
      chk("busywait", busywait,
          (m_phase != 0) || (cacc && !chit));
      chk("cpu_readdata", cpu_readdata, e_rd);
      chk("mem_read", mem_read, m_phase == 2);
      chk("mem_write", mem_write, m_phase == 1);
      chk("mem_address", mem_address, e_ma);
      chk("mem_writedata", mem_writedata, e_md);
      chk("hit_count", hit_count,
          (m_hits > 65535) ? 65535 : m_hits);
      chk("miss_count", miss_count,
          (m_misses > 65535) ? 65535 : m_misses);
    end
  end

  task automatic do_reset();
    reset = 1; cpu_read = 0; cpu_write = 0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 0;
  endtask

  // Issue one access and hold it until busywait drops
  task automatic do_access(input logic r, input logic w,
                           input logic [7:0] a, input logic [7:0] d,
                           output logic [7:0] rdata,
                           output int stall);
    cpu_read = r; cpu_write = w;
    cpu_address = a; cpu_writedata = d;
    stall = 0;
    @(negedge clock);
    while (busywait && stall < 200) begin
      stall++;
      @(negedge clock);
    end
    if (stall >= 200) chk("access_timeout", 1, 0);
    rdata = cpu_readdata;
    @(posedge clock);
    #1 cpu_read = 0; cpu_write = 0;
  endtask

  logic [7:0] rd;
  int st;

  initial begin
    clock = 0; reset = 1;
    cpu_read = 0; cpu_write = 0;
    cpu_address = 0; cpu_writedata = 0;
    s_read = 0; s_addr = 0;
    tnow = 0;
    clr_flags();
    for (int i = 0; i < 64; i++)
      mem[i] <= 32'hA0A0A0A0 ^ i;
    mem[0]  <= 32'hDDCCBBAA;
    mem[16] <= 32'h44434241;
    mem[32] <= 32'h88878685;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 0;
    chk_en = 1;

    // Reset state
    @(negedge clock);
    chk("rst_hit", hit_count, 0);
    chk("rst_miss", miss_count, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_busywait", busywait, 0);
    @(posedge clock);
    #1;

    // Cold miss with a slow memory
    lat = 3;
    clr_flags();
    do_access(1, 0, 8'h00, 8'h00, rd, st);
    chk("t1_rdata", rd, 8'hAA);
    chk("t1_mem_read", saw_rd, 1);
    chk("t1_mem_addr", rd_addr, 6'h00);
    chk("t1_miss", miss_count, 1);
    chk("t1_hit", hit_count, 0);

    // Zero-wait hit in the same block
    do_access(1, 0, 8'h01, 8'h00, rd, st);
    chk("t2_stall", st, 0);
    chk("t2_rdata", rd, 8'hBB);
    chk("t2_hit", hit_count, 1);

    // LRU eviction of a clean line
    lat = 1;
    do_access(1, 0, 8'h40, 8'h00, rd, st);
    chk("t3_rdata40", rd, 8'h41);
    do_access(1, 0, 8'h00, 8'h00, rd, st);
    chk("t3_stall00", st, 0);
    clr_flags();
    do_access(1, 0, 8'h80, 8'h00, rd, st);
    chk("t3_rdata80", rd, 8'h85);
    chk("t3_no_wb", saw_wr, 0);
    chk("t3_rd_addr", rd_addr, 6'h20);
    do_access(1, 0, 8'h00, 8'h00, rd, st);
    chk("t3_keep00", st, 0);
    chk("t3_rdata00", rd, 8'hAA);
    do_access(1, 0, 8'h40, 8'h00, rd, st);
    chk("t3_evicted40", st != 0, 1);

    // Dirty eviction writes back merged block
    do_reset();
    do_access(1, 0, 8'h00, 8'h00, rd, st);
    do_access(0, 1, 8'h02, 8'h55, rd, st);
    chk("t4_write_hit", st, 0);
    do_access(1, 0, 8'h40, 8'h00, rd, st);
    clr_flags();
    do_access(1, 0, 8'h80, 8'h00, rd, st);
    chk("t4_wb", saw_wr, 1);
    chk("t4_wb_addr", wr_addr, 6'h00);
    chk("t4_wb_data", wr_data, 32'hDD55BBAA);
    chk("t4_fetch_addr", rd_addr, 6'h20);
    chk("t4_order", wr_t < rd_t, 1);
    do_access(1, 0, 8'h02, 8'h00, rd, st);
    chk("t4_refetch", st != 0, 1);
    chk("t4_rdata", rd, 8'h55);
    chk("t4_miss", miss_count, 4);
    chk("t4_hit", hit_count, 1);

    // Reset in the middle of a fetch
    do_reset();
    lat = 3;
    cpu_read = 1; cpu_address = 8'h00;
    @(negedge clock);
    @(negedge clock);
    chk("t5_fetching", mem_read, 1);
    @(posedge clock);
    #1 reset = 1; cpu_read = 0;
    @(negedge clock);
    @(negedge clock);
    chk("t5_mem_read_off", mem_read, 0);
    chk("t5_hit", hit_count, 0);
    chk("t5_miss", miss_count, 0);
    @(posedge clock);
    #1 reset = 0;
    do_access(1, 0, 8'h00, 8'h00, rd, st);
    chk("t5_remiss", st != 0, 1);
    chk("t5_miss1", miss_count, 1);

    // Both strobes high is not an access
    clr_flags();
    cpu_read = 1; cpu_write = 1; cpu_address = 8'h00;
    @(negedge clock);
    chk("t6_busywait", busywait, 0);
    repeat (3) @(negedge clock);
    chk("t6_no_rd", saw_rd, 0);
    chk("t6_no_wr", saw_wr, 0);
    chk("t6_miss", miss_count, 1);
    chk("t6_hit", hit_count, 0);
    @(posedge clock);
    #1 cpu_read = 0; cpu_write = 0;

    // Saturation on the 4-bit counter instance
    for (int i = 0; i < 20; i++) begin
      int n;
      n = 0;
      s_addr = {4'(i % 16), 4'h0};
      s_read = 1;
      @(negedge clock);
      while (s_busywait && n < 50) begin
        n++;
        @(negedge clock);
      end
      if (n >= 50) chk("sat_timeout", 1, 0);
      @(posedge clock);
      #1;
      if (i == 4) chk("sat_miss5", s_miss_count, 4'h5);
    end
    chk("sat_miss", s_miss_count, 4'hF);
    chk("sat_hit0", s_hit_count, 4'h0);
    @(negedge clock);
    chk("sat_plain_hit", s_busywait, 0);
    @(posedge clock);
    #1 s_read = 0;
    chk("sat_hit1", s_hit_count, 4'h1);
    chk("sat_miss_hold", s_miss_count, 4'hF);

    @(negedge clock);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
